feature_map_writer: RTL and testbench

Receive-side counterpart of the clocked convolution window engine. Accepts the stream of convolved pixels it produces, one per handshake, and stores them row-major into an internal output feature-map buffer. Optionally accumulates onto existing contents so multi-channel convolutions sum into one map. Exposes a synchronous read port for the next layer (pooling or dense).

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/fmap_ram.sv | 45 ++++
 rtl/feature_map_writer.sv | 158 +++++++++++++++
 tb/tb_feature_map_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared defaults, FSM encoding and saturation helper for the CNN datapath blocks.
package cnn_pkg;

   localparam int N_DEF    = 32;
   localparam int DW_DEF   = 16;
   localparam int MAXF_DEF = 5;

   localparam logic signed [16:0] SAT_MAX = 17'sd32767;
   localparam logic signed [16:0] SAT_MIN = -17'sd32768;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fmw_state_t;

   function automatic logic [15:0] sat16(input logic signed [16:0] sum);
      if (sum > SAT_MAX) begin
         return 16'h7fff;
      end else if (sum < SAT_MIN) begin
         return 16'h8000;
      end else begin
         return sum[15:0];
      end
   endfunction

endpackage

// File: rtl/fmap_ram.sv
// Feature-map storage: one synchronous write port, an enabled read port for the
// read-modify-write path and an always-on read port for the next layer (1-cycle latency).
module fmap_ram #(
   parameter int DEPTH = 1024,
   parameter int DW    = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          ra_en,
   input  logic [AW-1:0] ra_addr,
   output logic [DW-1:0] ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ra_q;
   logic [DW-1:0] rb_q;

   // Array and RMW read register carry no reset: contents must survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (ra_en) begin
         ra_q <= mem[ra_addr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rb_q <= '0;
      end else begin
         rb_q <= mem[rb_addr];
      end
   end

   assign ra_data = ra_q;
   assign rb_data = rb_q;

endmodule

// File: rtl/feature_map_writer.sv
// Stores a raster stream of convolved pixels into a feature map, optionally summing onto it.
// Writes commit one edge after acceptance; in_ready is high only in RUN, no internal queueing.
module feature_map_writer
   import cnn_pkg::*;
#(
   parameter  int N    = N_DEF,
   parameter  int DW   = DW_DEF,
   parameter  int MAXF = MAXF_DEF,
   localparam int AW   = $clog2(N*N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [15:0]          imgSize,
   input  logic [15:0]          filterSize,
   input  logic                 accumulate,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   input  logic [AW-1:0]        rd_addr,
   output logic signed [DW-1:0] rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 sat
);

   fmw_state_t    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] last_q, last_d;
   logic          acc_q, acc_d;
   logic          err_q, err_d;
   logic          sat_q, sat_d;

   logic          wr_vld_q;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;

   logic          accept;
   logic          cfg_ok;
   logic [15:0]   o_side;
   logic [AW-1:0] last_cfg;
   logic [DW-1:0] old_dat;
   logic [DW-1:0] wr_dat;
   logic [DW-1:0] rb_dat;
   logic signed [DW:0] sum;
   logic          clip;

   // Odd filterSize implies filterSize >= 1, so no separate lower bound is needed.
   assign cfg_ok   = filterSize[0] && (filterSize <= 16'(MAXF)) &&
                     (filterSize <= imgSize) && (imgSize <= 16'(N));
   assign o_side   = imgSize - {filterSize[15:1], 1'b0};
   assign last_cfg = AW'(o_side * o_side - 16'd1);

   assign sum    = $signed({old_dat[DW-1], old_dat}) + $signed({wr_data_q[DW-1], wr_data_q});
   assign clip   = (sum > SAT_MAX) || (sum < SAT_MIN);
   assign wr_dat = acc_q ? sat16(sum) : wr_data_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      last_d   = last_q;
      acc_d    = acc_q;
      err_d    = err_q;
      sat_d    = sat_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      accept   = 1'b0;

      if (wr_vld_q && acc_q && clip) begin
         sat_d = 1'b1;
      end

      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               sat_d = 1'b0;
               if (cfg_ok) begin
                  state_d = RUN;
                  addr_d  = '0;
                  last_d  = last_cfg;
                  acc_d   = accumulate;
                  err_d   = 1'b0;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               addr_d = addr_q + AW'(1);
               if (addr_q == last_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         last_q    <= '0;
         acc_q     <= 1'b0;
         err_q     <= 1'b0;
         sat_q     <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         sat_q    <= sat_d;
         wr_vld_q <= accept;
         if (accept) begin
            wr_addr_q <= addr_q;
            wr_data_q <= in_data;
         end
      end
   end

   fmap_ram #(
      .DEPTH (N*N),
      .DW    (DW),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (wr_vld_q),
      .waddr   (wr_addr_q),
      .wdata   (wr_dat),
      .ra_en   (accept),
      .ra_addr (addr_q),
      .ra_data (old_dat),
      .rb_addr (rd_addr),
      .rb_data (rb_dat)
   );

   assign rd_data = rb_dat;
   assign err     = err_q;
   assign sat     = sat_q;

endmodule

// File: tb/tb_feature_map_writer.sv
// Scoreboard bench for feature_map_writer: a reference buffer model feeds expected read data.
module tb_feature_map_writer;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [15:0]        imgSize = '0;
   logic [15:0]        filterSize = '0;
   logic               accumulate = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_data = '0;
   logic               in_ready;
   logic [9:0]         rd_addr = '0;
   logic signed [15:0] rd_data;
   logic               busy, done, err, sat;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [15:0] model [1024];
   logic [15:0] exp_q [$];
   int          beats [$];
   bit          exp_sat = 1'b0;

   always #5 clk = ~clk;

   feature_map_writer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imgSize    (imgSize),
      .filterSize (filterSize),
      .accumulate (accumulate),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .sat        (sat)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
   endtask

   task automatic do_start(input int img, input int flt, input bit acc);
      start      = 1'b1;
      imgSize    = 16'(img);
      filterSize = 16'(flt);
      accumulate = acc;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   // Drives beats[0..n-1]; with gaps set, in_valid toggles every cycle.
   task automatic send_beats(input string tag, input int n, input bit gaps, input bit acc);
      int          idx = 0;
      int          cyc = 0;
      bit          tog = 1'b1;
      logic        rdy;
      logic [15:0] b;
      int          s;
      while (idx < n && cyc < 200) begin
         b        = 16'(beats[idx]);
         in_valid = gaps ? tog : 1'b1;
         in_data  = b;
         rdy      = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (in_valid && rdy) begin
            if (acc) begin
               s = int'($signed(model[idx])) + int'($signed(b));
               if (s > 32767) begin s = 32767; exp_sat = 1'b1; end
               if (s < -32768) begin s = -32768; exp_sat = 1'b1; end
               model[idx] = 16'(s);
            end else begin
               model[idx] = b;
            end
            idx++;
         end
         tog = ~tog;
      end
      in_valid = 1'b0;
      chk({tag, "_accepts"}, 32'(idx), 32'(n));
   endtask

   task automatic check_end(input string tag);
      chk({tag, "_drain_rdy"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_drain_done"}, {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic read_check(input string tag, input int a0, input int a1);
      for (int a = a0; a <= a1; a++) begin
         rd_addr = 10'(a);
         exp_q.push_back(model[a]);
         @(posedge clk); #1;
         chk(tag, {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdy"},  {31'd0, in_ready}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"},  {31'd0, err}, 32'd0);
      chk({tag, "_sat"},  {31'd0, sat}, 32'd0);
      chk({tag, "_rd"},   {16'd0, rd_data}, 32'd0);
   endtask

   task automatic illegal_start(input string tag, input int img, input int flt);
      int rdy_seen = 0;
      do_start(img, flt, 1'b0);
      chk({tag, "_err"},  {31'd0, err}, 32'd1);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      in_valid = 1'b1;
      in_data  = 16'sh5a5a;
      for (int i = 0; i < 6; i++) begin
         if (in_ready) rdy_seen++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk({tag, "_rdy_seen"}, 32'(rdy_seen), 32'd0);
      read_check({tag, "_unchanged"}, 0, 3);
   endtask

   initial begin
      int m3;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;
      @(posedge clk); #1;

      // Single-pixel map
      do_start(3, 3, 1'b0);
      chk("t1_start_rdy", {31'd0, in_ready}, 32'd1);
      chk("t1_start_busy", {31'd0, busy}, 32'd1);
      beats = {};
      beats.push_back(32'h0123);
      send_beats("t1", 1, 1'b0, 1'b0);
      check_end("t1");
      read_check("t1_rd", 0, 0);

      // 3x3 overwrite with valid gaps
      exp_sat = 1'b0;
      do_start(5, 3, 1'b0);
      beats = {};
      for (int i = 1; i <= 9; i++) beats.push_back(i);
      send_beats("t2", 9, 1'b1, 1'b0);
      check_end("t2");
      read_check("t2_rd", 0, 8);
      chk("t2_sat", {31'd0, sat}, {31'd0, exp_sat});

      // 3x3 accumulate
      do_start(5, 3, 1'b1);
      beats = {};
      for (int i = 1; i <= 9; i++) beats.push_back(10 * i);
      send_beats("t3", 9, 1'b1, 1'b1);
      check_end("t3");
      read_check("t3_rd", 0, 8);

      // Saturation in both directions on a 2x2 map
      exp_sat = 1'b0;
      do_start(2, 1, 1'b0);
      beats = {};
      beats.push_back(30000); beats.push_back(-30000); beats.push_back(5); beats.push_back(6);
      send_beats("t4a", 4, 1'b0, 1'b0);
      check_end("t4a");
      do_start(2, 1, 1'b1);
      beats = {};
      beats.push_back(30000); beats.push_back(-30000); beats.push_back(0); beats.push_back(0);
      send_beats("t4b", 4, 1'b0, 1'b1);
      check_end("t4b");
      chk("t4_sat", {31'd0, sat}, 32'd1);
      chk("t4_model_sat", {31'd0, sat}, {31'd0, exp_sat});
      read_check("t4_rd", 0, 3);
      chk("t4_pos_clamp", {16'd0, model[0]}, 32'h7fff);

      do_start(3, 3, 1'b0);
      chk("t5_sat_clr", {31'd0, sat}, 32'd0);
      beats = {};
      beats.push_back(7);
      send_beats("t5", 1, 1'b0, 1'b0);
      check_end("t5");

      illegal_start("e_flt4", 5, 4);
      illegal_start("e_img40", 40, 3);

      // Reset after four accepted beats: the fourth write is still in flight
      do_start(5, 3, 1'b0);
      chk("r_err_clr", {31'd0, err}, 32'd0);
      beats = {};
      for (int i = 0; i < 9; i++) beats.push_back(100 + i);
      m3 = int'(model[3]);
      send_beats("r_part", 4, 1'b0, 1'b0);
      model[3] = 16'(m3);
      reset = 1'b0;
      #1;
      check_reset_outputs("r_mid");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      read_check("r_kept", 0, 8);

      do_start(5, 3, 1'b0);
      beats = {};
      for (int i = 0; i < 9; i++) beats.push_back(200 + i);
      send_beats("r_full", 9, 1'b0, 1'b0);
      check_end("r_full");
      read_check("r_full_rd", 0, 8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_chk);
      $fatal(1);
   end

endmodule
